keypad_entry_ctrl: RTL and testbench

- Sequences keypad entry for the microwave cook-time register.
- Enables the keypad priority encoder, registers its BCD digit and active-low loadn strobe, and shifts accepted digits into a 4-digit MM:SS entry register.
- Hands the entered time to the countdown timer on start, and tracks cooking, pause and done phases.
- Sits between the keypad priority encoder and the timer/magnetron control.

---
 rtl/keypad_entry_ctrl_if.sv | 27 ++
 rtl/keypad_entry_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_entry_ctrl_if.sv
// Signal bundle between the keypad encoder / front panel / countdown timer (master)
// and keypad_entry_ctrl (slave).
interface keypad_entry_ctrl_if;
  logic [3:0]  bcd_in;
  logic        loadn;
  logic        start_n;
  logic        stop_n;
  logic        door_closed;
  logic        timer_zero;
  logic        enablen;
  logic [15:0] entry_time;
  logic        load_timer;
  logic        timer_run;
  logic        mag_on;
  logic        done;
  logic [2:0]  state;

  modport master (
    output bcd_in, loadn, start_n, stop_n, door_closed, timer_zero,
    input  enablen, entry_time, load_timer, timer_run, mag_on, done, state
  );

  modport slave (
    input  bcd_in, loadn, start_n, stop_n, door_closed, timer_zero,
    output enablen, entry_time, load_timer, timer_run, mag_on, done, state
  );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Microwave keypad entry controller: captures BCD keys into an MM:SS entry register and
// sequences IDLE/ENTRY/COOK/PAUSE/DONE. Optional macro DEBOUNCE_EN adds a loadn low-time filter.
module keypad_entry_ctrl #(
  parameter int MAX_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DONE_CYCLES     = 8
) (
  input logic                clk,
  input logic                rst,
  keypad_entry_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int CW  = $clog2(MAX_DIGITS + 1);
  localparam int DCW = $clog2(DONE_CYCLES + 1);

  function automatic logic is_bcd_digit(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

  state_t         state_r;
  state_t         state_nx;
  logic [1:0]     loadn_sync_r;
  logic [1:0]     start_sync_r;
  logic [1:0]     stop_sync_r;
  logic           loadn_synced_s;
  logic           start_s;
  logic           stop_s;
  logic           key_event_s;
  logic           accept_s;
  logic           key_drop_s;
  logic           shift_s;
  logic           entry_nonzero_s;
  logic           done_expired_s;
  logic [15:0]    entry_r;
  logic [CW-1:0]  digit_count_r;
  logic [DCW-1:0] done_cnt_r;
  logic           enablen_r;
  logic           load_timer_r;
  logic           timer_run_r;
  logic           mag_on_r;
  logic           done_r;
  logic           enablen_nx;
  logic           load_timer_nx;
  logic           timer_run_nx;
  logic           mag_on_nx;
  logic           done_nx;

  // Two-flop synchronisers for the asynchronous front-panel strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loadn_sync_r <= 2'b11;
      start_sync_r <= 2'b11;
      stop_sync_r  <= 2'b11;
    end else begin
      loadn_sync_r <= {loadn_sync_r[0], bus.loadn};
      start_sync_r <= {start_sync_r[0], bus.start_n};
      stop_sync_r  <= {stop_sync_r[0], bus.stop_n};
    end
  end

  assign loadn_synced_s = loadn_sync_r[1];
  assign start_s        = ~start_sync_r[1];
  assign stop_s         = ~stop_sync_r[1];

`ifdef DEBOUNCE_EN
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [DBW-1:0] deb_cnt_r;

  // Low-time counter: restarts on any high sample, saturates so a held key fires only once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt_r <= '0;
    end else if (loadn_synced_s) begin
      deb_cnt_r <= '0;
    end else if (deb_cnt_r != DBW'(DEBOUNCE_CYCLES)) begin
      deb_cnt_r <= deb_cnt_r + DBW'(1);
    end else begin
      deb_cnt_r <= deb_cnt_r;
    end
  end

  assign key_event_s = ~loadn_synced_s & (deb_cnt_r == DBW'(DEBOUNCE_CYCLES - 1));
`else
  logic loadn_prev_r;

  // Previous synced loadn, for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loadn_prev_r <= 1'b1;
    end else begin
      loadn_prev_r <= loadn_synced_s;
    end
  end

  assign key_event_s = loadn_prev_r & ~loadn_synced_s;
`endif

  // A start in ENTRY or any stop swallows a key arriving in the same cycle.
  assign accept_s        = key_event_s & ~enablen_r & ((state_r == S_IDLE) | (state_r == S_ENTRY));
  assign key_drop_s      = stop_s | (start_s & (state_r == S_ENTRY));
  assign shift_s         = accept_s & ~key_drop_s & is_bcd_digit(bus.bcd_in)
                           & (digit_count_r < CW'(MAX_DIGITS));
  assign entry_nonzero_s = |entry_r;
  assign done_expired_s  = (done_cnt_r == DCW'(DONE_CYCLES - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state logic; stop is checked first everywhere except COOK, where a finished timer wins.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      S_IDLE: begin
        if (shift_s) state_nx = S_ENTRY;
        else         state_nx = S_IDLE;
      end
      S_ENTRY: begin
        if (stop_s)                                          state_nx = S_IDLE;
        else if (start_s && bus.door_closed && entry_nonzero_s) state_nx = S_COOK;
        else                                                 state_nx = S_ENTRY;
      end
      S_COOK: begin
        if (bus.timer_zero)                     state_nx = S_DONE;
        else if (stop_s || !bus.door_closed)    state_nx = S_PAUSE;
        else                                    state_nx = S_COOK;
      end
      S_PAUSE: begin
        if (stop_s)                             state_nx = S_IDLE;
        else if (start_s && bus.door_closed)    state_nx = S_COOK;
        else                                    state_nx = S_PAUSE;
      end
      S_DONE: begin
        if (stop_s || done_expired_s) state_nx = S_IDLE;
        else                          state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Output decode from the next state so every output is a flop aligned with state_r.
  always_comb begin
    enablen_nx    = 1'b1;
    load_timer_nx = 1'b0;
    timer_run_nx  = 1'b0;
    mag_on_nx     = 1'b0;
    done_nx       = 1'b0;
    case (state_nx)
      S_IDLE, S_ENTRY: begin
        enablen_nx = 1'b0;
      end
      S_COOK: begin
        timer_run_nx  = 1'b1;
        mag_on_nx     = 1'b1;
        load_timer_nx = (state_r == S_ENTRY);
      end
      S_PAUSE: begin
        enablen_nx = 1'b1;
      end
      S_DONE: begin
        done_nx = 1'b1;
      end
      default: begin
        enablen_nx = 1'b0;
      end
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enablen_r    <= 1'b0;
      load_timer_r <= 1'b0;
      timer_run_r  <= 1'b0;
      mag_on_r     <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      enablen_r    <= enablen_nx;
      load_timer_r <= load_timer_nx;
      timer_run_r  <= timer_run_nx;
      mag_on_r     <= mag_on_nx;
      done_r       <= done_nx;
    end
  end

  // Entry register: cleared whenever the machine rests in IDLE, shifts accepted digits otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_r       <= 16'h0000;
      digit_count_r <= '0;
    end else if (state_nx == S_IDLE) begin
      entry_r       <= 16'h0000;
      digit_count_r <= '0;
    end else if (shift_s) begin
      entry_r       <= {entry_r[11:0], bus.bcd_in};
      digit_count_r <= digit_count_r + CW'(1);
    end else begin
      entry_r       <= entry_r;
      digit_count_r <= digit_count_r;
    end
  end

  // Dwell counter for the DONE indication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_cnt_r <= '0;
    end else if (state_r == S_DONE) begin
      done_cnt_r <= done_cnt_r + DCW'(1);
    end else begin
      done_cnt_r <= '0;
    end
  end

  assign bus.enablen    = enablen_r;
  assign bus.load_timer = load_timer_r;
  assign bus.timer_run  = timer_run_r;
  assign bus.mag_on     = mag_on_r;
  assign bus.done       = done_r;
  assign bus.entry_time = entry_r;
  assign bus.state      = state_r;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Scoreboard bench for keypad_entry_ctrl: a digit-queue reference model predicts each visible
// output change, load pulse and done dwell; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_keypad_entry_ctrl;
  localparam int DONE_CYCLES = 8;
  localparam int ST_IDLE = 0, ST_ENTRY = 1, ST_COOK = 2, ST_PAUSE = 3, ST_DONE = 4;
`ifdef DEBOUNCE_EN
  localparam int PRESS = 20;
`else
  localparam int PRESS = 5;
`endif

  typedef struct packed {
    logic [2:0]  st;
    logic [15:0] entry;
    logic        enablen;
    logic        run;
    logic        mag;
    logic        done;
  } snap_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keypad_entry_ctrl_if bus ();

  keypad_entry_ctrl #(
    .MAX_DIGITS(4), .DEBOUNCE_CYCLES(16), .DONE_CYCLES(DONE_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int        vectors = 0;
  int        fails   = 0;
  snap_t     snap_q[$];
  bit        load_q[$];
  int        done_len_q[$];
  int        m_st;
  logic [3:0] m_dig[$];
  logic      m_door;
  snap_t     m_snap;
  bit        mon_en = 1'b0;
  snap_t     prev_s;
  int        done_run = 0;

  function automatic snap_t exp_snap(int st, logic [15:0] e);
    snap_t s;
    s.st      = st[2:0];
    s.entry   = e;
    s.enablen = (st != ST_IDLE) && (st != ST_ENTRY);
    s.run     = (st == ST_COOK);
    s.mag     = (st == ST_COOK);
    s.done    = (st == ST_DONE);
    return s;
  endfunction

  function automatic logic [15:0] m_entry();
    logic [15:0] v;
    v = 16'h0000;
    foreach (m_dig[i]) v = {v[11:0], m_dig[i]};
    return v;
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.st = bus.state; s.entry = bus.entry_time; s.enablen = bus.enablen;
    s.run = bus.timer_run; s.mag = bus.mag_on; s.done = bus.done;
    return s;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic commit(int st);
    snap_t s;
    s = exp_snap(st, m_entry());
    m_st = st;
    if (s != m_snap) snap_q.push_back(s);
    m_snap = s;
  endtask

  // Monitor: every visible output change, load pulse and done dwell is matched against the queues.
  always @(negedge clk) begin
    snap_t cur;
    int    e;
    cur = dut_snap();
    if (mon_en) begin
      if (cur !== prev_s) begin
        if (snap_q.size() == 0) begin
          vectors++; fails++;
          $display("FAIL unexpected_change: got %h previous %h at %0t", cur, prev_s, $time);
        end else begin
          check("output_change", 32'(cur), 32'(snap_q.pop_front()));
        end
      end
      if (bus.load_timer === 1'b1) begin
        if (load_q.size() == 0) begin
          vectors++; fails++;
          $display("FAIL unexpected_load_timer: got 1 expected 0 at %0t", $time);
        end else begin
          void'(load_q.pop_front());
          check("load_timer_state", 32'(bus.state), ST_COOK);
        end
      end
      if (cur.done) begin
        done_run++;
      end else if (done_run != 0) begin
        if (done_len_q.size() == 0) begin
          vectors++; fails++;
          $display("FAIL unexpected_done: got %0d cycles expected none", done_run);
        end else begin
          e = done_len_q.pop_front();
          if (e == 0) check("done_cut_short", 32'(done_run < DONE_CYCLES), 32'd1);
          else        check("done_length", 32'(done_run), 32'(e));
        end
        done_run = 0;
      end
    end
    prev_s = cur;
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sync_check(string name);
    @(negedge clk);
    #1;
    check({name, "_outputs"}, 32'(dut_snap()), 32'(m_snap));
    check({name, "_drained"}, 32'(snap_q.size() + load_q.size() + done_len_q.size()), 32'd0);
  endtask

  task automatic key(logic [3:0] d);
    if ((m_st == ST_IDLE || m_st == ST_ENTRY) && d <= 4'd9 && m_dig.size() < 4) begin
      m_dig.push_back(d);
      commit(ST_ENTRY);
    end
    bus.bcd_in = d; bus.loadn = 1'b0;
    cyc(PRESS);
    bus.loadn = 1'b1;
    cyc(6);
  endtask

  task automatic model_start();
    if (m_st == ST_ENTRY && m_door && m_entry() != 16'h0000) begin
      load_q.push_back(1'b1);
      commit(ST_COOK);
    end else if (m_st == ST_PAUSE && m_door) begin
      commit(ST_COOK);
    end
  endtask

  task automatic model_stop();
    if (m_st == ST_COOK) begin
      commit(ST_PAUSE);
    end else if (m_st != ST_IDLE) begin
      m_dig.delete();
      commit(ST_IDLE);
    end
  endtask

  task automatic start_btn();
    model_start();
    bus.start_n = 1'b0; cyc(1); bus.start_n = 1'b1; cyc(6);
  endtask

  task automatic stop_btn();
    model_stop();
    bus.stop_n = 1'b0; cyc(1); bus.stop_n = 1'b1; cyc(6);
  endtask

  task automatic set_door(logic v);
    m_door = v;
    if (!v && m_st == ST_COOK) commit(ST_PAUSE);
    bus.door_closed = v;
    cyc(4);
  endtask

  task automatic timer_done(bit cut);
    if (m_st == ST_COOK) begin
      commit(ST_DONE);
      done_len_q.push_back(cut ? 0 : DONE_CYCLES);
      m_dig.delete();
      commit(ST_IDLE);
    end
    bus.timer_zero = 1'b1; cyc(1); bus.timer_zero = 1'b0;
    if (cut) begin
      cyc(3);
      bus.stop_n = 1'b0; cyc(1); bus.stop_n = 1'b1;
      cyc(6);
    end else begin
      cyc(DONE_CYCLES + 6);
    end
  endtask

  // Key pressed together with a button held for the same time; the button must win.
  task automatic key_with(logic [3:0] d, bit with_stop);
    if (with_stop) model_stop();
    else           model_start();
    bus.bcd_in = d; bus.loadn = 1'b0;
    if (with_stop) bus.stop_n = 1'b0;
    else           bus.start_n = 1'b0;
    cyc(PRESS);
    bus.loadn = 1'b1; bus.stop_n = 1'b1; bus.start_n = 1'b1;
    cyc(6);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.bcd_in = 4'd0; bus.loadn = 1'b1; bus.start_n = 1'b1; bus.stop_n = 1'b1;
    bus.door_closed = 1'b1; bus.timer_zero = 1'b0;
    rst = 1'b0;
    #2 rst = 1'b1;
    #2;
    check("reset_outputs", 32'(dut_snap()), 32'(exp_snap(ST_IDLE, 16'h0000)));
    check("reset_load_timer", 32'(bus.load_timer), 32'd0);
    m_st = ST_IDLE; m_door = 1'b1; m_snap = exp_snap(ST_IDLE, 16'h0000);
    cyc(3);
    rst = 1'b0;
    cyc(2);
    mon_en = 1'b1;

    key(4'd1); key(4'd3); key(4'd0);
    sync_check("entry_0130");
    stop_btn();
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    sync_check("entry_1234_full");
    stop_btn();
    key(4'd0); key(4'd0); key(4'd3); key(4'd0);
    start_btn();
    sync_check("cook_0030");
    timer_done(1'b0);
    sync_check("done_to_idle");
    key(4'd1); key(4'd5); start_btn();
    set_door(1'b0);
    sync_check("door_pause");
    set_door(1'b1); start_btn();
    sync_check("resume_no_load");
    stop_btn(); stop_btn();
    sync_check("stop_stop_idle");
    key(4'd0); start_btn();
    sync_check("start_zero_entry");
    set_door(1'b0); key(4'd2); start_btn();
    sync_check("start_door_open");
    set_door(1'b1); key(4'd7); key_with(4'd5, 1'b1);
    sync_check("stop_and_key");
    key(4'd4); start_btn(); timer_done(1'b1);
    sync_check("stop_in_done");
    key(4'd1); key_with(4'd9, 1'b0);
    sync_check("start_and_key");
    stop_btn(); stop_btn();
    key(4'd11);
    sync_check("bcd_over_9");
`ifdef DEBOUNCE_EN
    bus.bcd_in = 4'd8; bus.loadn = 1'b0; cyc(5); bus.loadn = 1'b1; cyc(6);
    sync_check("glitch_ignored");
    key(4'd6);
    sync_check("debounced_key");
    stop_btn();
`endif

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 11))
        0, 1, 2, 3, 4, 11: key(4'($urandom_range(0, 11)));
        5, 6:              start_btn();
        7:                 stop_btn();
        8:                 set_door(~m_door);
        default:           timer_done(1'b0);
      endcase
      if (i % 25 == 24) sync_check("random");
    end

    set_door(1'b1); stop_btn(); stop_btn();
    key(4'd2); start_btn();
    sync_check("pre_reset_cook");
    m_dig.delete(); m_st = ST_IDLE;
    m_snap = exp_snap(ST_IDLE, 16'h0000);
    snap_q.push_back(m_snap);
    rst = 1'b1;
    #1;
    check("midcook_rst_state", 32'(bus.state), 32'd0);
    check("midcook_rst_entry", 32'(bus.entry_time), 32'd0);
    check("midcook_rst_enablen", 32'(bus.enablen), 32'd0);
    check("midcook_rst_load", 32'(bus.load_timer), 32'd0);
    check("midcook_rst_run", 32'(bus.timer_run), 32'd0);
    check("midcook_rst_mag", 32'(bus.mag_on), 32'd0);
    check("midcook_rst_done", 32'(bus.done), 32'd0);
    cyc(2);
    rst = 1'b0;
    cyc(4);
    sync_check("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
